// File: rtl/jtag_types_pkg.sv
// Shared types and helpers for the JTAG/SoC async FIFO crossing.
package jtag_types_pkg;

  typedef struct packed {
    logic full;
    logic afull;
    logic overflow;
  } wptr_flags_t;

  // Usable in localparam expressions to size the FIFO from its address width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/flex_bin2gray.sv
// Width-generic binary<->Gray converter; BIN2GRAY=1 encodes, BIN2GRAY=0 decodes.
module flex_bin2gray #(
  parameter int W        = 5,
  parameter bit BIN2GRAY = 1'b1
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout[W-1] = din[W-1];

  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_bit
      if (BIN2GRAY) begin : g_enc
        assign dout[gi] = din[gi] ^ din[gi+1];
      end else begin : g_dec
        // Each binary bit is the XOR of all Gray bits at or above it.
        assign dout[gi] = ^din[W-1:gi];
      end
    end
  endgenerate

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller of the async FIFO.
// Optional build macro WPTR_AFULL_EN adds the afull_thresh port and almost-full comparator.
module wptr_full_ctrl
  import jtag_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   sync_rptr,
`ifdef WPTR_AFULL_EN
  input  logic [ADDR_WIDTH:0]   afull_thresh,
`endif
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wen,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  afull,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] wcount_reg;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl_next;
  wptr_flags_t   flags_reg;
  wptr_flags_t   flags_next;

  flex_bin2gray #(.W(PW), .BIN2GRAY(1'b1)) u_wptr_enc (
    .din  (wbin_next),
    .dout (wgray_next)
  );

  flex_bin2gray #(.W(PW), .BIN2GRAY(1'b0)) u_rptr_dec (
    .din  (sync_rptr),
    .dout (rbin)
  );

  assign wen       = winc && !flags_reg.full;
  assign wbin_next = wbin_reg + PW'(wen);
  // Level against the current synchronised read pointer; wraps mod 2**PW.
  assign lvl_next  = wbin_next - rbin;

  always_comb begin
    flags_next       = flags_reg;
    flags_next.full  = (lvl_next == DEPTH_P);
`ifdef WPTR_AFULL_EN
    flags_next.afull = (lvl_next >= afull_thresh);
`else
    flags_next.afull = 1'b0;
`endif
    // A dropped write sets overflow and wins over a same-cycle clear.
    if (winc && flags_reg.full) begin
      flags_next.overflow = 1'b1;
    end else if (ovf_clr) begin
      flags_next.overflow = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wbin_reg   <= '0;
      wptr_reg   <= '0;
      wcount_reg <= '0;
      flags_reg  <= '0;
    end else begin
      wbin_reg   <= wbin_next;
      wptr_reg   <= wgray_next;
      wcount_reg <= lvl_next;
      flags_reg  <= flags_next;
    end
  end

  assign waddr    = wbin_reg[ADDR_WIDTH-1:0];
  assign wptr     = wptr_reg;
  assign wcount   = wcount_reg;
  assign full     = flags_reg.full;
  assign afull    = flags_reg.afull;
  assign overflow = flags_reg.overflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl with ADDR_WIDTH=2 (DEPTH=4).
module tb_wptr_full_ctrl;

`ifdef WPTR_AFULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic       wclk = 1'b0;
  logic       w_rst;
  logic       winc;
  logic [2:0] sync_rptr;
  logic [2:0] afull_thresh;
  logic       ovf_clr;
  logic [1:0] waddr;
  logic       wen;
  logic [2:0] wptr;
  logic       full;
  logic [2:0] wcount;
  logic       afull;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 wclk = ~wclk;

  wptr_full_ctrl #(.ADDR_WIDTH(2)) dut (
    .wclk         (wclk),
    .w_rst        (w_rst),
    .winc         (winc),
    .sync_rptr    (sync_rptr),
`ifdef WPTR_AFULL_EN
    .afull_thresh (afull_thresh),
`endif
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wen          (wen),
    .wptr         (wptr),
    .full         (full),
    .wcount       (wcount),
    .afull        (afull),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Registered outputs after an edge; afull expectation collapses to 0 without the feature.
  task automatic expect_state(input string tag, input logic [1:0] e_waddr, input logic [2:0] e_wptr,
                              input logic [2:0] e_wcount, input logic e_full, input logic e_afull,
                              input logic e_ovf);
    check({tag, ".waddr"},    32'(waddr),    32'(e_waddr));
    check({tag, ".wptr"},     32'(wptr),     32'(e_wptr));
    check({tag, ".wcount"},   32'(wcount),   32'(e_wcount));
    check({tag, ".full"},     32'(full),     32'(e_full));
    check({tag, ".afull"},    32'(afull),    32'(e_afull & AF_EN));
    check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    $display("step %-10s waddr=%0d wptr=%03b wcount=%0d full=%0b afull=%0b ovf=%0b",
             tag, waddr, wptr, wcount, full, afull, overflow);
  endtask

  initial begin
    w_rst = 1'b1; winc = 1'b1; sync_rptr = 3'b000; afull_thresh = 3'd3; ovf_clr = 1'b0;
    tick(); tick();
    expect_state("reset", 2'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);

    winc = 1'b0; w_rst = 1'b0;
    tick();
    expect_state("idle", 2'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    check("idle.wen", 32'(wen), 32'd0);

    // Fill the FIFO
    winc = 1'b1; #1;
    check("wr1.wen", 32'(wen), 32'd1);
    tick(); expect_state("wr1", 2'd1, 3'b001, 3'd1, 1'b0, 1'b0, 1'b0);
    tick(); expect_state("wr2", 2'd2, 3'b011, 3'd2, 1'b0, 1'b0, 1'b0);
    tick(); expect_state("wr3", 2'd3, 3'b010, 3'd3, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("wr4", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1, 1'b0);

    // Write while full is dropped and flagged
    check("wr5.wen", 32'(wen), 32'd0);
    tick(); expect_state("wr5", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1, 1'b1);
    ovf_clr = 1'b1;
    tick(); expect_state("ovf_pri", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1, 1'b1);
    winc = 1'b0;
    tick(); expect_state("ovf_clr", 2'd0, 3'b110, 3'd4, 1'b1, 1'b1, 1'b0);
    ovf_clr = 1'b0;

    // Read side frees one slot, then refill
    sync_rptr = 3'b001;
    tick(); expect_state("rd1", 2'd0, 3'b110, 3'd3, 1'b0, 1'b1, 1'b0);
    winc = 1'b1; #1;
    check("refill.wen", 32'(wen), 32'd1);
    tick(); expect_state("refill", 2'd1, 3'b111, 3'd4, 1'b1, 1'b1, 1'b0);

    winc = 1'b0; sync_rptr = 3'b010;  // rbin=3
    tick(); expect_state("rd3", 2'd1, 3'b111, 3'd2, 1'b0, 1'b0, 1'b0);
    winc = 1'b1; sync_rptr = 3'b110;  // rbin=4, simultaneous write
    tick(); expect_state("wr_rd", 2'd2, 3'b101, 3'd2, 1'b0, 1'b0, 1'b0);

    // Wrap of the binary counter 7 -> 0
    tick(); expect_state("wrap7", 2'd3, 3'b100, 3'd3, 1'b0, 1'b1, 1'b0);
    tick(); expect_state("wrap0", 2'd0, 3'b000, 3'd4, 1'b1, 1'b1, 1'b0);
    sync_rptr = 3'b111;  // rbin=5, winc dropped this cycle
    tick(); expect_state("wrap_rd", 2'd0, 3'b000, 3'd3, 1'b0, 1'b1, 1'b1);
    tick(); expect_state("wrap1", 2'd1, 3'b001, 3'd4, 1'b1, 1'b1, 1'b1);
    winc = 1'b0; sync_rptr = 3'b001;  // rbin=1, empty
    tick(); expect_state("empty", 2'd1, 3'b001, 3'd0, 1'b0, 1'b0, 1'b1);

    // Mid-operation reset with winc high, then threshold 0
    w_rst = 1'b1; winc = 1'b1; sync_rptr = 3'b000; afull_thresh = 3'd0;
    tick(); expect_state("rst_mid", 2'd0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    w_rst = 1'b0; winc = 1'b0;
    tick(); expect_state("thresh0", 2'd0, 3'b000, 3'd0, 1'b0, 1'b1, 1'b0);

    // Threshold above DEPTH never asserts afull
    afull_thresh = 3'd5; winc = 1'b1;
    tick(); tick(); tick(); tick();
    expect_state("thresh5", 2'd0, 3'b110, 3'd4, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
